// File: rtl/div2_pow_seq.sv
// -----------------------------------------------------------------------------
// div2_pow_seq
//
// Sequential divide-by-x^k unit over the 8-bit ring GF(2)[x]/(x^8+x^2+1).
// A request (in_data, in_k) is accepted in IDLE. The unit then applies the
// x^-1 step once per cycle for k cycles and presents a*x^-k in DONE until the
// consumer takes it.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer holds valid (and its payload) until that edge, and
// ready never depends combinationally on valid.
//
// Parameters:
//   KW         width of the step count, maximum k = 2^KW - 1
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   request present
//   in_ready   block can accept a request (IDLE only)
//   in_data    operand byte, sampled on the accept edge
//   in_k       number of x^-1 steps, sampled on the accept edge
//   out_valid  result present (DONE)
//   out_ready  consumer accepts the result
//   out_data   a*x^-k while out_valid, otherwise 0x00
//   busy       high in RUN or DONE
//   chk_err    sticky step self-check failure (0 unless checking is built in)
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Build option:
//   DIV2_POW_SEQ_CHECK_EN  when defined, every RUN cycle re-multiplies the
//                          stepped value by x and compares it with the working
//                          value; a mismatch sets chk_err until rst. When
//                          undefined, chk_err is tied to 0.
// -----------------------------------------------------------------------------
module div2_pow_seq #(
  parameter int KW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic [KW-1:0] in_k,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          busy,
  output logic          chk_err,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [KW-1:0] CNT_ONE = KW'(1);
  localparam logic [KW-1:0] CNT_ZERO = '0;

  state_t        state;
  logic [7:0]    acc;
  logic [KW-1:0] cnt;
  logic [7:0]    acc_step;

  // One x^-1 step: rotate right, and fold the reduction bit (old b0, which
  // came from the x^2 term of the polynomial) back into bit 1.
  function automatic logic [7:0] step_div(input logic [7:0] b);
    logic [7:0] a;
    a[7] = b[0];
    a[6] = b[7];
    a[5] = b[6];
    a[4] = b[5];
    a[3] = b[4];
    a[2] = b[3];
    a[1] = b[2] ^ b[0];
    a[0] = b[1];
    return a;
  endfunction

  assign acc_step  = step_div(acc);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= 8'h00;
      cnt       <= CNT_ZERO;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            acc      <= in_data;
            cnt      <= in_k;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_k == CNT_ZERO) begin
              // Nothing to do: the operand is already the result.
              state     <= S_DONE;
              out_valid <= 1'b1;
              out_data  <= in_data;
            end else begin
              state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          acc <= acc_step;
          cnt <= cnt - CNT_ONE;
          // Last step still executes; its result is what DONE presents.
          if (cnt == CNT_ONE) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_data  <= acc_step;
          end
        end

        S_DONE: begin
          // in_ready stays low here so the next request lands only after
          // the result has left.
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_data  <= 8'h00;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIV2_POW_SEQ_CHECK_EN
  // Forward multiply-by-x: shift left, reduce by x^8 = x^2 + 1.
  function automatic logic [7:0] step_mul(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h05 : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err <= 1'b0;
    end else if (state == S_RUN && step_mul(acc_step) != acc) begin
      chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_div2_pow_seq.sv
// -----------------------------------------------------------------------------
// tb_div2_pow_seq
//
// Self-checking bench for div2_pow_seq. Expected results come from a
// brute-force inverse of the forward multiply-by-x map, so the reference never
// uses the x^-1 step equation itself.
// -----------------------------------------------------------------------------
module tb_div2_pow_seq;

  localparam int KW = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic [KW-1:0] in_k;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          busy;
  logic          chk_err;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] exp_q[$];

  div2_pow_seq #(.KW(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_k      (in_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .chk_err   (chk_err),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  function automatic logic [7:0] mul_x(input logic [7:0] a);
    logic [8:0] t;
    t = {a, 1'b0};
    if (t[8]) t = t ^ 9'h105;
    return t[7:0];
  endfunction

  function automatic logic [7:0] mul_xk(input logic [7:0] a, input int k);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < k; i++) r = mul_x(r);
    return r;
  endfunction

  // The unique c with c * x^k == v.
  function automatic logic [7:0] ref_div(input logic [7:0] v, input int k);
    logic [7:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 8'(i);
      if (mul_xk(c, k) == v) return c;
    end
    return 8'h00;
  endfunction

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- driver
  // One request: accept, count latency, optionally hold out_ready low for
  // 'hold' cycles in DONE, then take the result and compare.
  task automatic run_req(input logic [7:0] data, input int k, input int hold,
                         output logic [7:0] got);
    int n;
    logic [7:0] held;
    logic [7:0] exp;
    got = 8'h00;
    check("idle_in_ready", in_ready, 1);
    in_data   = data;
    in_k      = KW'(k);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 255);  // must not matter after accept
    in_k     = KW'($urandom_range(0, 7));
    exp_q.push_back(ref_div(data, k));
    check("busy_after_accept", busy, 1);
    n = 0;
    while (!out_valid && n < 40) begin
      check("in_ready_run", in_ready, 0);
      tick();
      n++;
    end
    check("latency", n, k);
    if (!out_valid) return;
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, held);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("done_in_ready", in_ready, 0);
    got = out_data;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("out_data", out_data, exp);
    end else begin
      check("scoreboard_empty", 1, 0);
    end
    check("roundtrip", mul_xk(out_data, k), data);
    tick();
    out_ready = 1'b0;
    check("post_in_ready", in_ready, 1);
    check("post_out_valid", out_valid, 0);
    check("post_out_data", out_data, 8'h00);
    check("post_busy", busy, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [7:0] r;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_k      = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_chk_err", chk_err, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    tick();

    run_req(8'h01, 1, 0, r);  check("tp_01_k1", r, 8'h82);
    check("chk_err_first", chk_err, 0);
    run_req(8'h01, 2, 0, r);  check("tp_01_k2", r, 8'h41);
    run_req(8'hFF, 1, 0, r);  check("tp_ff_k1", r, 8'hFD);
    run_req(8'h80, 1, 0, r);  check("tp_80_k1", r, 8'h40);
    run_req(8'h5A, 0, 0, r);  check("tp_5a_k0", r, 8'h5A);
    run_req(8'h00, 7, 0, r);  check("tp_00_k7", r, 8'h00);

    // Backpressure: result held for 5 cycles.
    run_req(8'h37, 1, 5, r);

    // Reset mid-operation.
    in_data  = 8'hC3;
    in_k     = KW'(7);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("midrst_running", dbg_state, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_state", dbg_state, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 8'h00);
    check("midrst_busy", busy, 0);
    exp_q.delete();

    // Reset beats a request in IDLE.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h11;
    in_k     = KW'(3);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_vs_valid_busy", busy, 0);
    check("rst_vs_valid_ready", in_ready, 1);
    tick();
    check("rst_vs_valid_idle", dbg_state, 0);

    // Random requests with occasional backpressure.
    for (int i = 0; i < 1000; i++) begin
      run_req(8'($urandom_range(0, 255)), $urandom_range(0, 7),
              ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0, r);
    end
    check("chk_err_final", chk_err, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
